// File: rtl/residual_pkg.sv
// Shared types, widths and saturation helper for the residual shortcut path.
package residual_pkg;

  localparam int DATA_W         = 16;
  localparam int TAP_N          = 4;
  localparam int FM_DEPTH_DEF   = 64;
  localparam int OUT_DEPTH_DEF  = 128;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef logic signed [DATA_W-1:0] data_t;
  typedef data_t shortcut_vec_t [FM_DEPTH_DEF];

  // Clamp a 17-bit two's-complement sum into the 16-bit signed range.
  function automatic data_t sat16(input logic signed [DATA_W:0] s);
    if (s > 17'sd32767)
      return data_t'(16'h7fff);
    else if (s < -17'sd32768)
      return data_t'(16'h8000);
    return data_t'(s[DATA_W-1:0]);
  endfunction

endpackage

// File: rtl/residual_fifo.sv
// Single-clock show-ahead FIFO of shortcut vectors; a push while full is accepted
// only when a pop frees the head slot in the same cycle.
module residual_fifo
  import residual_pkg::*;
#(
  parameter int  DEPTH = FIFO_DEPTH_DEF,
  parameter type T     = shortcut_vec_t
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  T                         din,
  output T                         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  T                   r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [LVL_W-1:0]   r_level;
  logic               w_do_push;
  logic               w_do_pop;

  assign full      = (r_level == LVL_W'(DEPTH));
  assign empty     = (r_level == '0);
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || pop);
  assign level     = r_level;
  assign dout      = r_mem[r_rd_ptr];

  // NOTE: storage has no reset; the level counter alone decides which slots are valid.
  always_ff @(posedge clk) begin
    if (w_do_push)
      r_mem[r_wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push)
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/residual_add.sv
// Residual shortcut: 2x2 average pooling into a FIFO, saturating add onto macro results.
// Define RES_ROUND_EN for round-half-up pooling; default is a truncating shift.
module residual_add
  import residual_pkg::*;
#(
  parameter int FM_DEPTH   = FM_DEPTH_DEF,
  parameter int OUT_DEPTH  = OUT_DEPTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                                       clk,
  input  logic                                       rstn,
  input  logic                                       verticle_sync,
  input  logic                                       mode_in,
  input  logic                                       res_valid,
  input  logic [FM_DEPTH-1:0][TAP_N-1:0][DATA_W-1:0] res,
  input  logic                                       macro_valid,
  input  logic [OUT_DEPTH-1:0][DATA_W-1:0]           macro_data,
  output logic                                       out_valid,
  output logic [OUT_DEPTH-1:0][DATA_W-1:0]           out_data,
  output logic [$clog2(FIFO_DEPTH):0]                fifo_level,
  output logic                                       overflow,
  output logic                                       underflow
);

  typedef data_t sc_vec_t [FM_DEPTH];

  logic                              w_clear;
  logic                              w_push;
  logic                              w_pop;
  logic                              w_full;
  logic                              w_empty;
  sc_vec_t                           w_pool;
  sc_vec_t                           w_head;
  logic [OUT_DEPTH-1:0][DATA_W-1:0]  w_sum_next;
  logic                              r_out_valid;
  logic [OUT_DEPTH-1:0][DATA_W-1:0]  r_out_data;
  logic                              r_overflow;
  logic                              r_underflow;

  assign w_clear = verticle_sync || !mode_in;
  assign w_push  = res_valid && !w_clear;
  assign w_pop   = macro_valid && !w_clear;

  // Four 16-bit taps summed in 18 bits; the shifted result always fits 16 bits.
  for (genvar c = 0; c < FM_DEPTH; c++) begin : g_pool
    logic signed [DATA_W+1:0] w_tap_sum;
    assign w_tap_sum = 18'($signed(res[c][0])) + 18'($signed(res[c][1]))
                     + 18'($signed(res[c][2])) + 18'($signed(res[c][3]));
`ifdef RES_ROUND_EN
    assign w_pool[c] = data_t'((w_tap_sum + 18'sd2) >>> 2);
`else
    assign w_pool[c] = data_t'(w_tap_sum >>> 2);
`endif
  end

  residual_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (sc_vec_t)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .clear (w_clear),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_pool),
    .dout  (w_head),
    .level (fifo_level),
    .full  (w_full),
    .empty (w_empty)
  );

  // Channels beyond the shortcut width see a zero shortcut; an empty FIFO passes macro data through.
  for (genvar c = 0; c < OUT_DEPTH; c++) begin : g_add
    if (c < FM_DEPTH) begin : g_sc
      assign w_sum_next[c] = w_empty ? macro_data[c]
                           : sat16(17'($signed(macro_data[c])) + 17'(w_head[c]));
    end else begin : g_pad
      assign w_sum_next[c] = macro_data[c];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (w_clear) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_out_valid <= macro_valid;
      if (macro_valid)
        r_out_data <= w_sum_next;
      if (res_valid && w_full && !macro_valid)
        r_overflow <= 1'b1;
      if (macro_valid && w_empty)
        r_underflow <= 1'b1;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule
